serial_axadd: RTL and testbench

SERIAL_AXADD -- requirements
Module: serial_axadd

---
 rtl/serial_axadd.sv | 124 ++++++++++++
 tb/tb_serial_axadd.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_axadd.sv
// Bit-serial adder, LSB first, one bit per clock through a single carry flop.
// mode selects exact (0/3) or one of two approximate full-adder cells (1/2).
module serial_axadd #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [1:0]       mode_q, mode_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic ai, bi, p, s_bit, c_nxt;

    // One adder cell evaluated on the bit selected by the counter
    always_comb begin
        ai    = a_q[cnt_q];
        bi    = b_q[cnt_q];
        p     = ai ^ bi;
        s_bit = 1'b0;
        c_nxt = 1'b0;
        case (mode_q)
            2'd1: begin
                c_nxt = p ? carry_q : ai;
                s_bit = ~c_nxt;
            end
            2'd2: begin
                s_bit = p ^ carry_q;
                c_nxt = s_bit;
            end
            default: begin
                s_bit = p ^ carry_q;
                c_nxt = p ? carry_q : ai;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                carry_d = c_nxt;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    cout_d  = c_nxt;
                    cnt_d   = '0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_axadd.sv
// Directed and regression bench for serial_axadd at WIDTH=8.
module tb_serial_axadd;

    logic       clk = 1'b0;
    logic       rst, start, cin;
    logic [1:0] mode;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;

    int checks = 0;
    int errors = 0;

    serial_axadd #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Launch one operation, scramble inputs after capture, wait (bounded) for done.
    task automatic do_op(input logic [1:0] m, input logic [7:0] aa, input logic [7:0] bb,
                         input logic ci, output logic [7:0] s, output logic co,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        mode = m; a = aa; b = bb; cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~aa; b = 8'h5a; mode = ~m; cin = ~ci;
        lat = 0;
        busy_cnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) break;
            @(posedge clk);
            lat++;
        end
        s  = sum;
        co = cout;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end
        rst = 1'b0;
    endtask

    task automatic test_exact;
        logic [7:0] s; logic co; int lat, bc;
        do_op(2'd0, 8'hFF, 8'h01, 1'b0, s, co, lat, bc);
        checks++;
        if ({co, s} !== 9'h100) begin
            errors++; $display("FAIL exact_ff_01 got %b_%h want 1_00", co, s);
        end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL latency got %0d want 8", lat); end
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL busy_cycles got %0d want 8", bc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_done got %b want 0", busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b want 0", done); end
        do_op(2'd0, 8'hA5, 8'h3C, 1'b1, s, co, lat, bc);
        checks++;
        if ({co, s} !== 9'h0E2) begin
            errors++; $display("FAIL exact_a5_3c got %b_%h want 0_e2", co, s);
        end
        // Results hold while idle
        repeat (3) @(negedge clk);
        checks++;
        if ({cout, sum} !== 9'h0E2) begin
            errors++; $display("FAIL hold_idle got %b_%h want 0_e2", cout, sum);
        end
    endtask

    task automatic test_mode1;
        logic [7:0] s; logic co; int lat, bc;
        do_op(2'd1, 8'h01, 8'h01, 1'b0, s, co, lat, bc);
        checks++;
        if ({co, s} !== 9'h0FE) begin
            errors++; $display("FAIL mode1 got %b_%h want 0_fe", co, s);
        end
    endtask

    task automatic test_mode2_3;
        logic [7:0] s; logic co; int lat, bc;
        do_op(2'd2, 8'h03, 8'h01, 1'b0, s, co, lat, bc);
        checks++;
        if ({co, s} !== 9'h1FE) begin
            errors++; $display("FAIL mode2 got %b_%h want 1_fe", co, s);
        end
        do_op(2'd3, 8'h03, 8'h01, 1'b1, s, co, lat, bc);
        checks++;
        if ({co, s} !== 9'h005) begin
            errors++; $display("FAIL mode3 got %b_%h want 0_05", co, s);
        end
    endtask

    task automatic test_back_to_back;
        int ndone, overlap;
        logic [19:0] seen;
        @(negedge clk);
        mode = 2'd0; a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        ndone = 0; overlap = 0; seen = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            seen[k] = done;
            if (done) ndone++;
            if (done && busy) overlap++;
        end
        start = 1'b0;
        checks++;
        if (seen !== 20'h40100) begin
            errors++; $display("FAIL b2b_done_pattern got %h want 40100", seen);
        end
        checks++;
        if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL b2b_busy_done got %0d want 0", overlap); end
        checks++;
        if ({cout, sum} !== 9'h003) begin
            errors++; $display("FAIL b2b_result got %b_%h want 0_03", cout, sum);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [7:0] s; logic co; int lat, bc, nd;
        do_op(2'd0, 8'hFF, 8'h01, 1'b0, s, co, lat, bc);
        @(negedge clk);
        mode = 2'd0; a = 8'h0F; b = 8'h00; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL aborted_activity got %0d want 0", nd); end
        do_op(2'd0, 8'h10, 8'h20, 1'b0, s, co, lat, bc);
        checks++;
        if ({co, s} !== 9'h030) begin
            errors++; $display("FAIL after_reset got %b_%h want 0_30", co, s);
        end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL after_reset_lat got %0d want 8", lat); end
    endtask

    task automatic test_random;
        logic [7:0] s, ra, rb; logic co, rc; int lat, bc;
        logic [8:0] exp_v;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp_v = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            do_op(2'd0, ra, rb, rc, s, co, lat, bc);
            checks++;
            if ({co, s} !== exp_v || lat !== 8) begin
                errors++;
                $display("FAIL random %h+%h+%b got %b_%h lat %0d want %h lat 8",
                         ra, rb, rc, co, s, lat, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_mode1();
        test_mode2_3();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
